// File: rtl/ppi_data_bus_buffer_reg_pkg.sv
// ----------------------------------------------------------------------------
// ppi_pkg
// Shared definitions for the PPI data-bus buffer:
//   ppi_state_e       - direction FSM state and its externally visible encoding
//   PPI_DEFAULT_WIDTH - default data-bus width
//   turn_cnt_width()  - bits needed to hold a turnaround count of cycles-1
// ----------------------------------------------------------------------------
package ppi_pkg;

    localparam int PPI_DEFAULT_WIDTH = 8;

    // Encoding is visible on dir_state, so the values are fixed.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TO_PORT = 2'd1,
        TO_CPU  = 2'd2,
        TURN    = 2'd3
    } ppi_state_e;

    // The counter is loaded with cycles-1, so $clog2(cycles) bits suffice;
    // keep at least one bit for the single-dead-cycle case.
    function automatic int turn_cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/ppi_data_bus_buffer_reg_if.sv
// ----------------------------------------------------------------------------
// ppi_data_bus_buffer_reg_if
// Control/status group of the PPI data-bus buffer.
//   enable        - chip-select, 1 = buffer may drive either side
//   control_logic - direction, 1 = port bus -> CPU bus, 0 = CPU bus -> port bus
//   busy          - 1 while the buffer is in a turnaround
//   dir_state     - registered FSM state (IDLE=0, TO_PORT=1, TO_CPU=2, TURN=3)
// Modports: master = controller side, slave = buffer side.
// ----------------------------------------------------------------------------
interface ppi_data_bus_buffer_reg_if;
    logic       enable;
    logic       control_logic;
    logic       busy;
    logic [1:0] dir_state;

    modport master (
        output enable,
        output control_logic,
        input  busy,
        input  dir_state
    );

    modport slave (
        input  enable,
        input  control_logic,
        output busy,
        output dir_state
    );
endinterface

// File: rtl/ppi_data_bus_buffer_reg_turn_counter.sv
// ----------------------------------------------------------------------------
// bus_turn_counter
// Down-counter timing the dead cycles of a bus turnaround.
//   clk, rst - clock and synchronous active-high reset (count -> 0)
//   load_i   - load TURN_CYCLES-1 (takes priority over dec_i)
//   dec_i    - decrement by one; holds at zero
//   zero_o   - count is zero
// ----------------------------------------------------------------------------
module bus_turn_counter
    import ppi_pkg::*;
#(
    parameter int TURN_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);
    localparam int            CW       = turn_cnt_width(TURN_CYCLES);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TURN_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LOAD_VAL;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);
endmodule

// File: rtl/ppi_data_bus_buffer_reg.sv
// ----------------------------------------------------------------------------
// ppi_data_bus_buffer_reg
// Registered bidirectional buffer between the processor data bus and the
// internal port bus, with guaranteed dead cycles on every direction change.
//   clk, rst - clock and synchronous active-high reset
//   ctrl     - slave modport: enable, control_logic in; busy, dir_state out
//   bus_cpu  - processor-side data bus (driven in TO_CPU with cpu_q)
//   bus      - port-side data bus (driven in TO_PORT with port_q)
// Both data registers sample their opposite bus on every edge, so driven data
// lags the source by one cycle. Tri-state enables decode only the registered
// state, so a side is never driven in the cycle after the other side was.
// ----------------------------------------------------------------------------
module ppi_data_bus_buffer_reg
    import ppi_pkg::*;
#(
    parameter int WIDTH       = PPI_DEFAULT_WIDTH,
    parameter int TURN_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    ppi_data_bus_buffer_reg_if.slave ctrl,
    inout  wire  [WIDTH-1:0]         bus_cpu,
    inout  wire  [WIDTH-1:0]         bus
);
    ppi_state_e       state_q;
    ppi_state_e       state_d;
    logic [WIDTH-1:0] port_q;
    logic [WIDTH-1:0] cpu_q;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             drive_port;
    logic             drive_cpu;
    logic             busy_c;

    bus_turn_counter #(
        .TURN_CYCLES (TURN_CYCLES)
    ) u_turn_counter (
        .clk    (clk),
        .rst    (rst),
        .load_i (cnt_load),
        .dec_i  (cnt_dec),
        .zero_o (cnt_zero)
    );

    // State register and data capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            port_q  <= '0;
            cpu_q   <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= bus_cpu;
            cpu_q   <= bus;
        end
    end

    // Next-state logic. Losing enable wins over any direction change, and the
    // direction selected on leaving TURN is whatever control_logic is then.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl.enable) begin
                    state_d = ctrl.control_logic ? TO_CPU : TO_PORT;
                end
            end
            TO_PORT: begin
                if (!ctrl.enable) begin
                    state_d = IDLE;
                end else if (ctrl.control_logic) begin
                    state_d  = TURN;
                    cnt_load = 1'b1;
                end
            end
            TO_CPU: begin
                if (!ctrl.enable) begin
                    state_d = IDLE;
                end else if (!ctrl.control_logic) begin
                    state_d  = TURN;
                    cnt_load = 1'b1;
                end
            end
            TURN: begin
                if (!ctrl.enable) begin
                    state_d = IDLE;
                end else if (cnt_zero) begin
                    state_d = ctrl.control_logic ? TO_CPU : TO_PORT;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the registered state only.
    always_comb begin
        drive_port = 1'b0;
        drive_cpu  = 1'b0;
        busy_c     = 1'b0;
        case (state_q)
            TO_PORT: drive_port = 1'b1;
            TO_CPU:  drive_cpu  = 1'b1;
            TURN:    busy_c     = 1'b1;
            default: ;
        endcase
    end

    assign bus            = drive_port ? port_q : {WIDTH{1'bz}};
    assign bus_cpu        = drive_cpu  ? cpu_q  : {WIDTH{1'bz}};
    assign ctrl.busy      = busy_c;
    assign ctrl.dir_state = state_q;
endmodule

// File: tb/tb_ppi_data_bus_buffer_reg.sv
// ----------------------------------------------------------------------------
// tb_ppi_data_bus_buffer_reg
// Two instances: A (WIDTH=8, TURN_CYCLES=3) and B (WIDTH=16, TURN_CYCLES=2).
// The bench drives each bus through its own tri-state driver; a side the DUT
// should leave floating is driven by the bench and must read back unchanged.
// ----------------------------------------------------------------------------
module tb_ppi_data_bus_buffer_reg;
    localparam int TC_A = 3;
    localparam int TC_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A
    logic        a_rst;
    logic        a_cpu_oe, a_port_oe;
    logic [7:0]  a_cpu_drv, a_port_drv;
    wire  [7:0]  a_bus_cpu, a_bus;
    ppi_data_bus_buffer_reg_if a_if ();
    assign a_bus_cpu = a_cpu_oe  ? a_cpu_drv  : 8'bz;
    assign a_bus     = a_port_oe ? a_port_drv : 8'bz;

    ppi_data_bus_buffer_reg #(.WIDTH(8), .TURN_CYCLES(TC_A)) u_a (
        .clk     (clk),
        .rst     (a_rst),
        .ctrl    (a_if),
        .bus_cpu (a_bus_cpu),
        .bus     (a_bus)
    );

    // Instance B
    logic        b_rst;
    logic        b_cpu_oe, b_port_oe;
    logic [15:0] b_cpu_drv, b_port_drv;
    wire  [15:0] b_bus_cpu, b_bus;
    ppi_data_bus_buffer_reg_if b_if ();
    assign b_bus_cpu = b_cpu_oe  ? b_cpu_drv  : 16'bz;
    assign b_bus     = b_port_oe ? b_port_drv : 16'bz;

    ppi_data_bus_buffer_reg #(.WIDTH(16), .TURN_CYCLES(TC_B)) u_b (
        .clk     (clk),
        .rst     (b_rst),
        .ctrl    (b_if),
        .bus_cpu (b_bus_cpu),
        .bus     (b_bus)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        a_rst = 1'b1; a_if.enable = 1'b0; a_if.control_logic = 1'b0;
        b_rst = 1'b1; b_if.enable = 1'b0; b_if.control_logic = 1'b0;
        a_cpu_oe = 1'b1; a_cpu_drv = 8'h5A; a_port_oe = 1'b1; a_port_drv = 8'hC3;
        b_cpu_oe = 1'b1; b_cpu_drv = 16'h1234; b_port_oe = 1'b1; b_port_drv = 16'hABCD;
        tick(); tick();
        checks++; if (a_if.dir_state !== 2'd0) begin errors++; $display("FAIL reset_a_dir got %0d want 0", a_if.dir_state); end
        checks++; if (a_if.busy !== 1'b0) begin errors++; $display("FAIL reset_a_busy got %b want 0", a_if.busy); end
        checks++; if (a_bus_cpu !== 8'h5A) begin errors++; $display("FAIL reset_a_bus_cpu_z got %h want 5a", a_bus_cpu); end
        checks++; if (a_bus !== 8'hC3) begin errors++; $display("FAIL reset_a_bus_z got %h want c3", a_bus); end
        checks++; if (u_a.port_q !== 8'h00) begin errors++; $display("FAIL reset_a_port_q got %h want 00", u_a.port_q); end
        checks++; if (u_a.cpu_q !== 8'h00) begin errors++; $display("FAIL reset_a_cpu_q got %h want 00", u_a.cpu_q); end
        checks++; if (b_if.dir_state !== 2'd0) begin errors++; $display("FAIL reset_b_dir got %0d want 0", b_if.dir_state); end
        checks++; if (b_if.busy !== 1'b0) begin errors++; $display("FAIL reset_b_busy got %b want 0", b_if.busy); end
        checks++; if (b_bus_cpu !== 16'h1234 || b_bus !== 16'hABCD) begin
            errors++; $display("FAIL reset_b_buses_z got %h/%h want 1234/abcd", b_bus_cpu, b_bus);
        end
        $display("test_reset done");
    endtask

    task automatic test_write();
        a_rst = 1'b0; a_if.enable = 1'b1; a_if.control_logic = 1'b0;
        a_cpu_oe = 1'b1; a_cpu_drv = 8'hA5; a_port_oe = 1'b0;
        tick();
        checks++; if (a_if.dir_state !== 2'd1) begin errors++; $display("FAIL write_dir got %0d want 1", a_if.dir_state); end
        tick();
        checks++; if (a_bus !== 8'hA5) begin errors++; $display("FAIL write_bus got %h want a5", a_bus); end
        checks++; if (a_bus_cpu !== 8'hA5) begin errors++; $display("FAIL write_bus_cpu_z got %h want a5", a_bus_cpu); end
        a_if.enable = 1'b0; a_port_oe = 1'b1; a_port_drv = 8'h00;
        tick();
        checks++; if (a_if.dir_state !== 2'd0) begin errors++; $display("FAIL write_disable_dir got %0d want 0", a_if.dir_state); end
        $display("test_write done");
    endtask

    task automatic test_read();
        a_if.enable = 1'b1; a_if.control_logic = 1'b1;
        a_port_oe = 1'b1; a_port_drv = 8'h3C; a_cpu_oe = 1'b0;
        tick();
        checks++; if (a_if.dir_state !== 2'd2) begin errors++; $display("FAIL read_dir got %0d want 2", a_if.dir_state); end
        checks++; if (a_bus_cpu !== 8'h3C) begin errors++; $display("FAIL read_bus_cpu got %h want 3c", a_bus_cpu); end
        checks++; if (a_bus !== 8'h3C) begin errors++; $display("FAIL read_bus_z got %h want 3c", a_bus); end
        a_if.enable = 1'b0; a_cpu_oe = 1'b1; a_cpu_drv = 8'h00;
        tick();
        $display("test_read done");
    endtask

    task automatic test_turn();
        a_if.enable = 1'b1; a_if.control_logic = 1'b0;
        a_cpu_oe = 1'b1; a_cpu_drv = 8'h11; a_port_oe = 1'b0;
        tick();
        checks++; if (a_bus !== 8'h11) begin errors++; $display("FAIL turn_pre_bus got %h want 11", a_bus); end
        a_if.control_logic = 1'b1;
        a_port_oe = 1'b1; a_port_drv = 8'h00; a_cpu_drv = 8'h00;
        for (int k = 0; k < TC_A; k++) begin
            tick();
            checks++; if (a_if.busy !== 1'b1 || a_if.dir_state !== 2'd3) begin
                errors++; $display("FAIL turn_busy cyc %0d got busy=%b dir=%0d want 1/3", k, a_if.busy, a_if.dir_state);
            end
            checks++; if (a_bus !== 8'h00 || a_bus_cpu !== 8'h00) begin
                errors++; $display("FAIL turn_z cyc %0d got %h/%h want 00/00", k, a_bus, a_bus_cpu);
            end
        end
        a_port_drv = 8'h5A; a_cpu_oe = 1'b0;
        tick();
        checks++; if (a_if.busy !== 1'b0 || a_if.dir_state !== 2'd2) begin
            errors++; $display("FAIL turn_exit got busy=%b dir=%0d want 0/2", a_if.busy, a_if.dir_state);
        end
        checks++; if (a_bus_cpu !== 8'h5A) begin errors++; $display("FAIL turn_exit_data got %h want 5a", a_bus_cpu); end
        a_if.enable = 1'b0; a_cpu_oe = 1'b1;
        tick();
        $display("test_turn done");
    endtask

    task automatic test_turn_abort();
        a_if.enable = 1'b1; a_if.control_logic = 1'b0;
        a_cpu_oe = 1'b1; a_cpu_drv = 8'h77; a_port_oe = 1'b0;
        tick();
        a_if.control_logic = 1'b1; a_port_oe = 1'b1; a_port_drv = 8'h00; a_cpu_drv = 8'h00;
        tick();
        checks++; if (a_if.busy !== 1'b1) begin errors++; $display("FAIL abort_in_turn got busy=%b want 1", a_if.busy); end
        a_if.enable = 1'b0;
        tick();
        checks++; if (a_if.busy !== 1'b0 || a_if.dir_state !== 2'd0) begin
            errors++; $display("FAIL abort_idle got busy=%b dir=%0d want 0/0", a_if.busy, a_if.dir_state);
        end
        checks++; if (a_bus !== 8'h00 || a_bus_cpu !== 8'h00) begin
            errors++; $display("FAIL abort_z got %h/%h want 00/00", a_bus, a_bus_cpu);
        end
        $display("test_turn_abort done");
    endtask

    task automatic test_turn_toggle();
        b_rst = 1'b0; b_if.enable = 1'b1; b_if.control_logic = 1'b1;
        b_port_oe = 1'b1; b_port_drv = 16'h1234; b_cpu_oe = 1'b0;
        tick();
        checks++; if (b_if.dir_state !== 2'd2) begin errors++; $display("FAIL toggle_pre_dir got %0d want 2", b_if.dir_state); end
        b_if.control_logic = 1'b0; b_cpu_oe = 1'b1; b_cpu_drv = 16'h0000; b_port_drv = 16'h0000;
        tick();
        checks++; if (b_if.busy !== 1'b1) begin errors++; $display("FAIL toggle_turn1 got busy=%b want 1", b_if.busy); end
        b_if.control_logic = 1'b1;
        tick();
        checks++; if (b_if.busy !== 1'b1 || b_if.dir_state !== 2'd3) begin
            errors++; $display("FAIL toggle_turn2 got busy=%b dir=%0d want 1/3", b_if.busy, b_if.dir_state);
        end
        b_cpu_oe = 1'b0; b_port_drv = 16'h0F0F;
        tick();
        checks++; if (b_if.busy !== 1'b0 || b_if.dir_state !== 2'd2) begin
            errors++; $display("FAIL toggle_exit got busy=%b dir=%0d want 0/2", b_if.busy, b_if.dir_state);
        end
        checks++; if (b_bus_cpu !== 16'h0F0F) begin errors++; $display("FAIL toggle_exit_data got %h want 0f0f", b_bus_cpu); end
        b_if.enable = 1'b0; b_cpu_oe = 1'b1;
        tick();
        $display("test_turn_toggle done");
    endtask

    task automatic test_reset_mid_drive();
        a_if.enable = 1'b1; a_if.control_logic = 1'b1;
        a_port_oe = 1'b1; a_port_drv = 8'hFF; a_cpu_oe = 1'b0;
        b_if.enable = 1'b1; b_if.control_logic = 1'b1;
        b_port_oe = 1'b1; b_port_drv = 16'hBEEF; b_cpu_oe = 1'b0;
        tick();
        checks++; if (a_bus_cpu !== 8'hFF) begin errors++; $display("FAIL rstmid_a_pre got %h want ff", a_bus_cpu); end
        checks++; if (b_bus_cpu !== 16'hBEEF) begin errors++; $display("FAIL rstmid_b_pre got %h want beef", b_bus_cpu); end
        a_rst = 1'b1; a_cpu_oe = 1'b1; a_cpu_drv = 8'h00;
        b_rst = 1'b1; b_cpu_oe = 1'b1; b_cpu_drv = 16'h0000;
        tick();
        checks++; if (a_if.dir_state !== 2'd0 || a_if.busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_a_state got dir=%0d busy=%b want 0/0", a_if.dir_state, a_if.busy);
        end
        checks++; if (u_a.cpu_q !== 8'h00) begin errors++; $display("FAIL rstmid_a_cpu_q got %h want 00", u_a.cpu_q); end
        checks++; if (a_bus_cpu !== 8'h00) begin errors++; $display("FAIL rstmid_a_z got %h want 00", a_bus_cpu); end
        checks++; if (b_if.dir_state !== 2'd0 || b_if.busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_b_state got dir=%0d busy=%b want 0/0", b_if.dir_state, b_if.busy);
        end
        checks++; if (u_b.cpu_q !== 16'h0000) begin errors++; $display("FAIL rstmid_b_cpu_q got %h want 0000", u_b.cpu_q); end
        checks++; if (b_bus_cpu !== 16'h0000) begin errors++; $display("FAIL rstmid_b_z got %h want 0000", b_bus_cpu); end
        b_rst = 1'b0; b_if.enable = 1'b0;
        $display("test_reset_mid_drive done");
    endtask

    // Random enable/direction/reset on A against a mode + dead-cycle model.
    // m_drv: 0 none, 1 port side, 2 CPU side; m_dead > 0 means dead cycles left.
    task automatic test_random();
        int         m_drv;
        int         m_dead;
        int         want;
        logic [7:0] m_port, m_cpu, exp_cpu_bus, exp_port_bus;
        logic [1:0] exp_state;
        logic       exp_busy;
        a_rst = 1'b1; a_if.enable = 1'b0; a_if.control_logic = 1'b0;
        a_cpu_oe = 1'b1; a_port_oe = 1'b1;
        a_cpu_drv = 8'($urandom); a_port_drv = 8'($urandom);
        @(posedge clk); #1;
        m_drv = 0; m_dead = 0; m_port = 8'h00; m_cpu = 8'h00;
        for (int n = 0; n < 400; n++) begin
            a_cpu_oe   = !(m_dead == 0 && m_drv == 2);
            a_port_oe  = !(m_dead == 0 && m_drv == 1);
            a_cpu_drv  = 8'($urandom);
            a_port_drv = 8'($urandom);
            exp_cpu_bus  = a_cpu_oe  ? a_cpu_drv  : m_cpu;
            exp_port_bus = a_port_oe ? a_port_drv : m_port;
            exp_state    = (m_dead > 0) ? 2'd3 : 2'(m_drv);
            exp_busy     = (m_dead > 0);
            @(negedge clk);
            checks++; if (a_if.dir_state !== exp_state) begin errors++; $display("FAIL rand_dir cyc %0d got %0d want %0d", n, a_if.dir_state, exp_state); end
            checks++; if (a_if.busy !== exp_busy) begin errors++; $display("FAIL rand_busy cyc %0d got %b want %b", n, a_if.busy, exp_busy); end
            checks++; if (a_bus_cpu !== exp_cpu_bus) begin errors++; $display("FAIL rand_bus_cpu cyc %0d got %h want %h", n, a_bus_cpu, exp_cpu_bus); end
            checks++; if (a_bus !== exp_port_bus) begin errors++; $display("FAIL rand_bus cyc %0d got %h want %h", n, a_bus, exp_port_bus); end
            a_rst = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 5) == 0) a_if.enable = ~a_if.enable;
            else if (!a_if.enable && $urandom_range(0, 1) == 0) a_if.enable = 1'b1;
            if ($urandom_range(0, 3) == 0) a_if.control_logic = ~a_if.control_logic;
            @(posedge clk);
            if (a_rst) begin
                m_drv = 0; m_dead = 0; m_port = 8'h00; m_cpu = 8'h00;
            end else begin
                m_port = exp_cpu_bus;
                m_cpu  = exp_port_bus;
                want   = a_if.control_logic ? 2 : 1;
                if (!a_if.enable) begin
                    m_drv = 0; m_dead = 0;
                end else if (m_dead > 0) begin
                    m_dead--;
                    if (m_dead == 0) m_drv = want;
                end else if (m_drv == 0) begin
                    m_drv = want;
                end else if (m_drv != want) begin
                    m_drv = 0; m_dead = TC_A;
                end
            end
            #1;
        end
        @(negedge clk);
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_turn();
        test_turn_abort();
        test_turn_toggle();
        test_reset_mid_drive();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
